// File: rtl/ncpu32k_afifo_rd_stream_if.sv
// Read-side stream bundle: FIFO pop/empty side plus the valid/ready consumer side.
// The master modport belongs to the adapter; the slave modport to the FIFO/consumer.
interface ncpu32k_afifo_rd_stream_if #(
    parameter int DW = 32
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_pop;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_pop,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_pop,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/ncpu32k_afifo_rd_stream.sv
// Turns the dual-clock FIFO's pop/empty read port into a valid/ready stream via a small skid buffer.
// Optional flush port enabled by defining NCPU32K_AFIFO_RD_FLUSH_EN.
module ncpu32k_afifo_rd_stream #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                           rclk,
    input  logic                           rrst_n,
`ifdef NCPU32K_AFIFO_RD_FLUSH_EN
    input  logic                           flush,
`endif
    ncpu32k_afifo_rd_stream_if.master      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic          flush_s;
    logic          valid_s;
    logic          deq_s;
    logic          pop_s;
    logic          capture_s;
    logic [CW:0]   occ_s;

`ifdef NCPU32K_AFIFO_RD_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Next-state and handshake decode; a pop is issued only when a slot is guaranteed for its data.
    always_comb begin
        valid_s    = 1'b0;
        deq_s      = 1'b0;
        occ_s      = {(CW + 1){1'b0}};
        pop_s      = 1'b0;
        capture_s  = 1'b0;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (flush_s) begin
            cnt_d      = {CW{1'b0}};
            inflight_d = 1'b0;
            head_d     = {AW{1'b0}};
            tail_d     = {AW{1'b0}};
        end else begin
            valid_s    = (cnt_q != {CW{1'b0}});
            deq_s      = valid_s & bus.m_ready;
            occ_s      = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq_s};
            pop_s      = ~bus.fifo_empty & (occ_s < DEPTH_C);
            capture_s  = inflight_q;
            cnt_d      = occ_s[CW-1:0];
            inflight_d = pop_s;
            if (capture_s) begin
                tail_d = tail_q + AW'(1'b1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_s) begin
                head_d = head_q + AW'(1'b1);
            end else begin
                head_d = head_q;
            end
        end
    end

    // Occupancy, in-flight flag and pointers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q      <= {CW{1'b0}};
            inflight_q <= 1'b0;
            head_q     <= {AW{1'b0}};
            tail_q     <= {AW{1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Skid storage is deliberately not reset; nothing reads it until cnt is non-zero.
    always_ff @(posedge rclk) begin
        if (capture_s) begin
            mem_q[tail_q] <= bus.fifo_dout;
        end
    end

    assign bus.fifo_pop = pop_s;
    assign bus.m_valid  = valid_s;
    assign bus.m_data   = mem_q[head_q];
endmodule

// File: tb/tb_ncpu32k_afifo_rd_stream.sv
// Bench for ncpu32k_afifo_rd_stream: a behavioural FIFO model feeds the adapter, a scoreboard checks the stream.
module tb_ncpu32k_afifo_rd_stream;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic rclk = 1'b0;
    logic wclk = 1'b0;
    logic rrst_n = 1'b0;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int wr_cnt = 0;
    int wr_target = 0;

    ncpu32k_afifo_rd_stream_if #(.DW(DW)) bus ();

`ifdef NCPU32K_AFIFO_RD_FLUSH_EN
    ncpu32k_afifo_rd_stream #(.DW(DW), .DEPTH(DEPTH)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .flush(flush), .bus(bus)
    );
`else
    ncpu32k_afifo_rd_stream #(.DW(DW), .DEPTH(DEPTH)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .bus(bus)
    );
`endif

    initial forever #5 rclk = ~rclk;
    initial begin
        #3;
        forever #7 wclk = ~wclk;
    end

    function automatic logic [DW-1:0] mkword(input int n);
        logic [31:0] v;
        v = n;
        return {~v[15:0], v[15:0]};
    endfunction

    // FIFO read side: registered empty flag, data appears the cycle after a pop.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            bus.fifo_empty <= 1'b1;
            bus.fifo_dout  <= '0;
        end else if (bus.fifo_pop && fifo_q.size() != 0) begin
            bus.fifo_dout  <= fifo_q.pop_front();
            bus.fifo_empty <= (fifo_q.size() == 0);
        end else begin
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Writer in an unrelated clock domain, used for the long random run.
    always @(posedge wclk) begin
        if (wr_cnt < wr_target && $urandom_range(0, 1) == 1) begin
            fifo_q.push_back(mkword(wr_cnt));
            exp_q.push_back(mkword(wr_cnt));
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Invariants: never more reserved slots than storage, never a pop on an empty FIFO.
    always @(negedge rclk) begin
        if (rrst_n) begin
            if ((dut.cnt_q + dut.inflight_q) > DEPTH) begin
                errors++;
                $display("FAIL occupancy cnt+inflight=%0d limit=%0d", dut.cnt_q + dut.inflight_q, DEPTH);
            end
            if (bus.fifo_pop === 1'b1 && bus.fifo_empty === 1'b1) begin
                errors++;
                $display("FAIL pop_when_empty fifo_pop=1 required 0");
            end
        end
    end

    task automatic tick();
        @(negedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_nonempty(input string tag);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.fifo_empty === 1'b0) break;
        end
        checks++;
        if (bus.fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL %s_start fifo_empty=%b required 0 (timeout)", tag, bus.fifo_empty);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold m_valid=%b fifo_pop=%b required 0 0", bus.m_valid, bus.fifo_pop);
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b0 || dut.cnt_q !== 2'd0) begin
                errors++;
                $display("FAIL reset_release m_valid=%b fifo_pop=%b cnt=%0d required 0 0 0",
                         bus.m_valid, bus.fifo_pop, dut.cnt_q);
            end
        end
    endtask

    task automatic test_single();
        bus.m_ready = 1'b1;
        @(negedge rclk);
        push_word(32'h0000_00A1);
        wait_nonempty("single");
        checks++;
        if (bus.fifo_pop !== 1'b1 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_c0 fifo_pop=%b m_valid=%b required 1 0", bus.fifo_pop, bus.m_valid);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_c1 m_valid=%b required 0", bus.m_valid);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h0000_00A1) begin
            errors++;
            $display("FAIL single_c2 m_valid=%b m_data=%h required 1 000000a1", bus.m_valid, bus.m_data);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tick();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL single_c3 m_valid=%b fifo_pop=%b required 0 0", bus.m_valid, bus.fifo_pop);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        bus.m_ready = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        wait_nonempty("b2b");
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            checks++;
            if (bus.fifo_pop !== (c < 8) || bus.m_valid !== (c >= 2 && c < 10)) begin
                errors++;
                $display("FAIL b2b_timing cycle=%0d fifo_pop=%b m_valid=%b required %b %b",
                         c, bus.fifo_pop, bus.m_valid, (c < 8), (c >= 2 && c < 10));
            end
            if (bus.m_valid === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (bus.m_data !== e || e !== DW'(c - 2)) begin
                    errors++;
                    $display("FAIL b2b_data cycle=%0d m_data=%h required %h", c, bus.m_data, DW'(c - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e;
        int pops = 0;
        int got = 0;
        bus.m_ready = 1'b0;
        @(negedge rclk);
        for (int i = 0; i < 5; i++) push_word(DW'(i));
        wait_nonempty("bp");
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            if (bus.fifo_pop === 1'b1) pops++;
            if (bus.m_valid === 1'b1) begin
                checks++;
                if (bus.m_data !== 32'h0000_0000) begin
                    errors++;
                    $display("FAIL bp_stable cycle=%0d m_data=%h required 00000000", c, bus.m_data);
                end
            end
        end
        checks++;
        if (pops != DEPTH || dut.cnt_q !== 2'd2 || bus.fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall pops=%0d cnt=%0d fifo_pop=%b required %0d 2 0",
                     pops, dut.cnt_q, bus.fifo_pop, DEPTH);
        end
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            @(negedge rclk);
            bus.m_ready = 1'b1;
            #1;
            if (bus.m_valid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (bus.m_data !== e) begin
                    errors++;
                    $display("FAIL bp_drain word=%0d m_data=%h required %h", got, bus.m_data, e);
                end
            end
        end
        checks++;
        if (got != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count delivered=%0d required 5", got);
        end
        tick();
    endtask

    task automatic test_random_stream();
        logic [DW-1:0] e;
        int got = 0;
        wr_target = wr_cnt + 1000;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            @(negedge rclk);
            bus.m_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                got++;
                checks++;
                if (bus.m_data !== e) begin
                    errors++;
                    $display("FAIL rand_data word=%0d m_data=%h required %h", got, bus.m_data, e);
                end
            end
        end
        checks++;
        if (got != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count delivered=%0d required 1000", got);
        end
        bus.m_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset_midstream();
        bus.m_ready = 1'b0;
        @(negedge rclk);
        for (int i = 0; i < 5; i++) push_word(DW'(32'h50 + i));
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dut.inflight_q === 1'b1 && dut.cnt_q === 2'd1) break;
        end
        checks++;
        if (dut.inflight_q !== 1'b1 || dut.cnt_q !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_setup inflight=%b cnt=%0d required 1 1", dut.inflight_q, dut.cnt_q);
        end
        rrst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async m_valid=%b fifo_pop=%b required 0 0", bus.m_valid, bus.fifo_pop);
        end
        fifo_q.delete();
        exp_q.delete();
        repeat (2) tick();
        @(negedge rclk);
        rrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_idle m_valid=%b fifo_pop=%b required 0 0", bus.m_valid, bus.fifo_pop);
            end
        end
        test_single();
    endtask

`ifdef NCPU32K_AFIFO_RD_FLUSH_EN
    task automatic test_flush();
        logic [DW-1:0] e;
        int got = 0;
        bus.m_ready = 1'b0;
        @(negedge rclk);
        for (int i = 0; i < 5; i++) push_word(DW'(32'h70 + i));
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dut.inflight_q === 1'b1 && dut.cnt_q === 2'd1) break;
        end
        flush = 1'b1;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle m_valid=%b fifo_pop=%b required 0 0", bus.m_valid, bus.fifo_pop);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge rclk);
        flush = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.fifo_pop !== 1'b1) begin
            errors++;
            $display("FAIL flush_after m_valid=%b fifo_pop=%b required 0 1", bus.m_valid, bus.fifo_pop);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge rclk);
            bus.m_ready = 1'b1;
            #1;
            if (bus.m_valid === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (bus.m_data !== e) begin
                    errors++;
                    $display("FAIL flush_drain word=%0d m_data=%h required %h", got, bus.m_data, e);
                end
            end
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL flush_count delivered=%0d required 3", got);
        end
    endtask
`endif

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_reset_midstream();
`ifdef NCPU32K_AFIFO_RD_FLUSH_EN
        test_flush();
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
